// File: rtl/timepulse_monitor_pkg.sv
// Shared types and helpers for the timepulse monitor.
// Holds the TP bus width, the monitor state encoding and the
// one-hot index / successor functions used by the decoder and the FSM.
package tpmon_pkg;

    localparam int TP_WIDTH = 12;
    localparam logic [TP_WIDTH-1:0] T01 = 12'h001;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        HALT   = 2'd2
    } tpmon_state_e;

    // 1-based index of the single set bit; 0 when the word is not one-hot.
    function automatic logic [3:0] onehot_idx(input logic [TP_WIDTH-1:0] tp);
        logic [3:0] idx;
        int         ones;
        idx  = 4'd0;
        ones = 0;
        for (int i = 0; i < TP_WIDTH; i++) begin
            if (tp[i]) begin
                ones = ones + 1;
                idx  = 4'(i + 1);
            end
        end
        return (ones == 1) ? idx : 4'd0;
    endfunction

    // Next pulse in the T01..T12 ring.
    function automatic logic [3:0] tp_succ(input logic [3:0] idx);
        return (idx == 4'd12) ? 4'd1 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/timepulse_monitor_if.sv
// Timepulse bus between the timer side (master) and the monitor (slave).
// The timer side drives TP and the control strobes; the monitor returns
// lock/index status, the MCT strobe, the sticky alarms and the debug state.
// Bus timing: every signal is level-sampled on each rising CLOCK; there is no
// valid/ready handshake -- TP is valid every cycle, a change of a non-zero TP
// word is an event, and ALMCLR/GOJAM take effect on the edge they are seen.
interface timepulse_monitor_if;
    import tpmon_pkg::*;

    logic [TP_WIDTH-1:0] TP;
    logic                GOJAM;
    logic                STOP;
    logic                ALMCLR;

    logic                LOCK;
    logic [3:0]          TPIDX;
    logic                MCT;
    logic                CODEALM;
    logic                SEQALM;
    logic                STALLALM;
    logic                ALARM_n;
    logic [15:0]         MCTCNT;
    tpmon_state_e        STATE;

    modport master (
        output TP, GOJAM, STOP, ALMCLR,
        input  LOCK, TPIDX, MCT, CODEALM, SEQALM, STALLALM, ALARM_n, MCTCNT, STATE
    );

    modport slave (
        input  TP, GOJAM, STOP, ALMCLR,
        output LOCK, TPIDX, MCT, CODEALM, SEQALM, STALLALM, ALARM_n, MCTCNT, STATE
    );

endinterface

// File: rtl/timepulse_monitor_tp_onehot_decode.sv
// Combinational classifier for one TP word: one-hot, all-zero and 1-based index.
module tp_onehot_decode
    import tpmon_pkg::*;
(
    input  logic [TP_WIDTH-1:0] tp,
    output logic                is_onehot,
    output logic                is_zero,
    output logic [3:0]          index
);

    // Classify the word; a zero index means "not one-hot".
    always_comb begin
        index     = onehot_idx(tp);
        is_onehot = (index != 4'd0);
        is_zero   = (tp == '0);
    end

endmodule

// File: rtl/timepulse_monitor.sv
// Timepulse sequence monitor: tracks T01..T12 on the TP bus, raises sticky
// code/sequence/stall alarms and strobes MCT once per completed cycle.
// Optional macro TPMON_MCTCNT_EN builds a 16-bit wrapping MCT counter;
// without it MCTCNT reads as zero.
module timepulse_monitor
    import tpmon_pkg::*;
#(
    parameter int STALL_LIMIT = 32,
    parameter int STALL_W     = 6,
    parameter int GAP_MAX     = 3
) (
    input  logic                CLOCK,
    input  logic                SIM_RST,
    timepulse_monitor_if.slave  bus
);

    localparam int GAP_W = $clog2(GAP_MAX + 2);
    localparam logic [STALL_W-1:0] STALL_TRIP = STALL_W'(STALL_LIMIT);
    localparam logic [GAP_W-1:0]   GAP_TRIP   = GAP_W'(GAP_MAX + 1);

    tpmon_state_e        state;
    logic [TP_WIDTH-1:0] tp_q;
    logic [STALL_W-1:0]  stall_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic                lock;
    logic [3:0]          tpidx;
    logic                mct;
    logic                code_alm;
    logic                seq_alm;
    logic                stall_alm;

    logic                is_onehot;
    logic                is_zero;
    logic [3:0]          index;
    logic                ev;
    logic                set_code;
    logic                set_seq;
    logic                set_stall;

    tp_onehot_decode u_decode (
        .tp        (bus.TP),
        .is_onehot (is_onehot),
        .is_zero   (is_zero),
        .index     (index)
    );

    // Decide which alarm (if any) the current cycle raises; an event always
    // outranks the gap and stall timeouts.
    always_comb begin
        ev        = (bus.TP != tp_q) && !is_zero;
        set_code  = 1'b0;
        set_seq   = 1'b0;
        set_stall = 1'b0;
        if (state == LOCKED && !bus.GOJAM && !bus.STOP) begin
            if (ev) begin
                set_code = !is_onehot;
                set_seq  = is_onehot && (index != tp_succ(tpidx));
            end else begin
                set_seq   = is_zero && ((gap_cnt + GAP_W'(1)) == GAP_TRIP);
                set_stall = (stall_cnt + STALL_W'(1)) == STALL_TRIP;
            end
        end
    end

    // Monitor FSM with registered status, MCT strobe and sticky alarms.
    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            state     <= SYNC;
            tp_q      <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            lock      <= 1'b0;
            tpidx     <= 4'd0;
            mct       <= 1'b0;
            code_alm  <= 1'b0;
            seq_alm   <= 1'b0;
            stall_alm <= 1'b0;
        end else begin
            tp_q      <= bus.TP;
            mct       <= 1'b0;
            code_alm  <= (code_alm  & ~bus.ALMCLR) | set_code;
            seq_alm   <= (seq_alm   & ~bus.ALMCLR) | set_seq;
            stall_alm <= (stall_alm & ~bus.ALMCLR) | set_stall;
            if (bus.GOJAM) begin
                state     <= SYNC;
                lock      <= 1'b0;
                tpidx     <= 4'd0;
                stall_cnt <= '0;
                gap_cnt   <= '0;
            end else begin
                case (state)
                    SYNC: begin
                        if (!bus.STOP && bus.TP == T01) begin
                            state     <= LOCKED;
                            lock      <= 1'b1;
                            tpidx     <= 4'd1;
                            stall_cnt <= '0;
                            gap_cnt   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (bus.STOP) begin
                            state <= HALT;
                        end else if (set_code || set_seq || set_stall) begin
                            state     <= SYNC;
                            lock      <= 1'b0;
                            tpidx     <= 4'd0;
                            stall_cnt <= '0;
                            gap_cnt   <= '0;
                        end else if (ev) begin
                            tpidx     <= index;
                            stall_cnt <= '0;
                            gap_cnt   <= '0;
                            mct       <= (tpidx == 4'd12) && (index == 4'd1);
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                            gap_cnt   <= is_zero ? gap_cnt + GAP_W'(1) : '0;
                        end
                    end
                    HALT: begin
                        if (!bus.STOP) begin
                            state     <= LOCKED;
                            stall_cnt <= '0;
                            gap_cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= SYNC;
                        lock  <= 1'b0;
                        tpidx <= 4'd0;
                    end
                endcase
            end
        end
    end

`ifdef TPMON_MCTCNT_EN
    logic [15:0] mct_cnt;

    // Count MCT strobes; wraps naturally at 16 bits, cleared only by reset.
    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            mct_cnt <= 16'd0;
        end else if (mct) begin
            mct_cnt <= mct_cnt + 16'd1;
        end
    end

    assign bus.MCTCNT = mct_cnt;
`else
    assign bus.MCTCNT = 16'd0;
`endif

    assign bus.LOCK     = lock;
    assign bus.TPIDX    = tpidx;
    assign bus.MCT      = mct;
    assign bus.CODEALM  = code_alm;
    assign bus.SEQALM   = seq_alm;
    assign bus.STALLALM = stall_alm;
    assign bus.ALARM_n  = ~(code_alm | seq_alm | stall_alm);
    assign bus.STATE    = state;

endmodule
